// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU + BCD sequencer: default widths,
// opcode constants and the controller state encoding.
package alu_seq_pkg;

    localparam int DEF_DW = 5;
    localparam int DEF_RW = 10;
    localparam int DEF_ND = 3;

    localparam logic [2:0] OP_ZERO = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NOT  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/bcd_shift_unit.sv
// Iterative double-dabble datapath: load clears the digits and captures the
// magnitude, each step adds 3 to digits >= 5 then shifts the whole chain
// {digits, magnitude} left by one bit.
module bcd_shift_unit
    import alu_seq_pkg::*;
#(
    parameter int RW = DEF_RW,
    parameter int ND = DEF_ND
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [RW-1:0]   load_mag,
    output logic [4*ND-1:0] bcd
);

    logic [RW-1:0]      mag_q;
    logic [4*ND-1:0]    adj;
    logic [4*ND+RW-1:0] chain_next;

    // Add-3 correction on every digit, then the one-bit shift of the full chain
    always_comb begin
        adj = '0;
        for (int i = 0; i < ND; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            else
                adj[4*i +: 4] = bcd[4*i +: 4];
        end
        chain_next = {adj, mag_q} << 1;
    end

    // Digit and magnitude registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q <= '0;
            bcd   <= '0;
        end else if (load) begin
            mag_q <= load_mag;
            bcd   <= '0;
        end else if (step) begin
            bcd   <= chain_next[4*ND+RW-1:RW];
            mag_q <= chain_next[RW-1:0];
        end
    end

endmodule

// File: rtl/alu_bcd_sequencer.sv
// Multi-cycle sequencer: accepts (a, b, sel), computes the signed ALU result,
// converts its magnitude to three BCD digits one bit per cycle and holds the
// result until the consumer takes it.
// Optional: define ALU_OP_COUNT_EN to add an 8-bit completed-operation counter.
module alu_bcd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int RW = DEF_RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic [2:0]    in_sel,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef ALU_OP_COUNT_EN
    output logic [7:0]    op_count,
`endif
    output logic [RW-1:0] out_y,
    output logic          out_sign,
    output logic [3:0]    out_hundreds,
    output logic [3:0]    out_tens,
    output logic [3:0]    out_ones
);

    localparam int CW = $clog2(RW);

    seq_state_t       state_q, state_d;
    logic [DW-1:0]    a_q, b_q;
    logic [2:0]       sel_q;
    logic [CW-1:0]    cnt_q;
    logic [RW-1:0]    a_ext, b_ext, alu_y, mag;
    logic             load, step;
    logic [4*DEF_ND-1:0] bcd;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and datapath strobes
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: if (in_valid) state_d = CALC;
            CALC: begin
                load    = 1'b1;
                state_d = CONV;
            end
            CONV: begin
                step = 1'b1;
                if (cnt_q == '0) state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the request operands on the accept cycle only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            sel_q <= OP_ZERO;
        end else if (state_q == IDLE && in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            sel_q <= in_sel;
        end
    end

    // Signed ALU on operands sign-extended to the result width
    always_comb begin
        a_ext = {{(RW-DW){a_q[DW-1]}}, a_q};
        b_ext = {{(RW-DW){b_q[DW-1]}}, b_q};
        case (sel_q)
            OP_AND:  alu_y = a_ext & b_ext;
            OP_OR:   alu_y = a_ext | b_ext;
            OP_XOR:  alu_y = a_ext ^ b_ext;
            OP_NOT:  alu_y = ~a_ext;
            OP_SUB:  alu_y = a_ext - b_ext;
            OP_ADD:  alu_y = a_ext + b_ext;
            OP_MUL:  alu_y = a_ext * b_ext;
            default: alu_y = '0;
        endcase
        mag = alu_y[RW-1] ? (~alu_y + RW'(1)) : alu_y;
    end

    // Result register, loaded in CALC and held until the next CALC
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  out_y <= '0;
        else if (state_q == CALC) out_y <= alu_y;
    end

    // Conversion bit counter, one decrement per CONV cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 cnt_q <= '0;
        else if (state_q == CALC)                cnt_q <= CW'(RW-1);
        else if (state_q == CONV && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end

    bcd_shift_unit #(.RW(RW), .ND(DEF_ND)) u_bcd (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .load_mag (mag),
        .bcd      (bcd)
    );

`ifdef ALU_OP_COUNT_EN
    // Completed-handshake counter, wraps naturally at 8 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         op_count <= 8'd0;
        else if (out_valid && out_ready) op_count <= op_count + 8'd1;
    end
`endif

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign out_sign     = out_y[RW-1];
    assign out_hundreds = bcd[11:8];
    assign out_tens     = bcd[7:4];
    assign out_ones     = bcd[3:0];

endmodule
